// File: rtl/tpu_package.sv
// Shared TPU types and constants for the weight staging path.
package tpu_package;

  localparam int unsigned W_WIDTH  = 8;
  localparam int unsigned MUL_SIZE = 16;

  typedef logic [W_WIDTH:0] weight_row_t [MUL_SIZE];

endpackage

// File: rtl/weight_ring_ram.sv
// Simple dual-port row store: one write port, one registered read port.
module weight_ring_ram #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic [ADDR_W-1:0]              waddr_i,
  input  logic [LANES-1:0][DATA_W-1:0]   wdata_i,
  input  logic                           re_i,
  input  logic [ADDR_W-1:0]              raddr_i,
  output logic [LANES-1:0][DATA_W-1:0]   rdata_o
);

  logic [LANES-1:0][DATA_W-1:0] mem_q [DEPTH];
  logic [LANES-1:0][DATA_W-1:0] rdata_q;

  // Contents are never reset; only the output register is.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_ring_fifo.sv
// Pointer-based ring FIFO staging weight rows toward the systolic array,
// with level/threshold flags, tile-boundary marking and sticky errors.
module weight_ring_fifo
  import tpu_package::*;
#(
  parameter int unsigned LANES        = MUL_SIZE,
  parameter int unsigned DATA_W       = W_WIDTH + 1,
  parameter int unsigned DEPTH        = 128,
  parameter int unsigned AFULL_THRESH = DEPTH - LANES,
  parameter int unsigned TILE_ROWS    = LANES
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          wr_valid_i,
  input  logic [LANES-1:0][DATA_W-1:0]  wr_data_i,
  output logic                          wr_ready_o,
  input  logic                          rd_en_i,
  output logic                          rd_valid_o,
  output logic [LANES-1:0][DATA_W-1:0]  rd_data_o,
  output logic                          rd_tile_last_o,
  output logic [$clog2(DEPTH):0]        level_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic                          afull_o,
  output logic                          ovf_o,
  output logic                          udf_o
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;
  localparam int unsigned TC_W   = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("weight_ring_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("weight_ring_fifo: AFULL_THRESH must not exceed DEPTH");
  end
  if (TILE_ROWS < 1) begin : g_bad_tile
    $error("weight_ring_fifo: TILE_ROWS must be at least 1");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [TC_W-1:0]   tile_cnt_q, tile_cnt_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic              full, empty, wr_acc, rd_acc, tile_end;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign tile_end = (tile_cnt_q == TC_W'(TILE_ROWS - 1));

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    tile_cnt_d = tile_cnt_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    wr_acc     = 1'b0;
    rd_acc     = 1'b0;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      tile_cnt_d = '0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
    end else begin
      // Acceptance uses registered level only: no full-side or empty-side bypass.
      wr_acc = wr_valid_i & ~full;
      rd_acc = rd_en_i & ~empty;
      ovf_d  = ovf_q | (wr_valid_i & full);
      udf_d  = udf_q | (rd_en_i & empty);
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_valid_d = 1'b1;
        rd_last_d  = tile_end;
        tile_cnt_d = tile_end ? '0 : tile_cnt_q + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tile_cnt_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tile_cnt_q <= tile_cnt_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  weight_ring_ram #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_o)
  );

  assign wr_ready_o     = ~full;
  assign full_o         = full;
  assign empty_o        = empty;
  assign afull_o        = (level_q >= LVL_W'(AFULL_THRESH));
  assign level_o        = level_q;
  assign ovf_o          = ovf_q;
  assign udf_o          = udf_q;
  assign rd_valid_o     = rd_valid_q;
  assign rd_tile_last_o = rd_last_q;

endmodule

// File: tb/tb_weight_ring_fifo.sv
// Self-checking bench for weight_ring_fifo: queue-based reference model
// compared every cycle, plus hand-computed expectations per scenario.
module tb_weight_ring_fifo;

  localparam int LANES  = 4;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int TILE   = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush = 1'b0, wv = 1'b0, re = 1'b0;
  logic [LANES-1:0][DATA_W-1:0] wd = '0;

  logic                         wr_ready_o, rd_valid_o, rd_tile_last_o;
  logic [LANES-1:0][DATA_W-1:0] rd_data_o;
  logic [3:0]                   level_o;
  logic                         empty_o, full_o, afull_o, ovf_o, udf_o;

  always #5 clk = ~clk;

  weight_ring_fifo #(
    .LANES        (LANES),
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL),
    .TILE_ROWS    (TILE)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .wr_valid_i     (wv),
    .wr_data_i      (wd),
    .wr_ready_o     (wr_ready_o),
    .rd_en_i        (re),
    .rd_valid_o     (rd_valid_o),
    .rd_data_o      (rd_data_o),
    .rd_tile_last_o (rd_tile_last_o),
    .level_o        (level_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .afull_o        (afull_o),
    .ovf_o          (ovf_o),
    .udf_o          (udf_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] row(input int v);
    logic [8:0] lane;
    lane = 9'(v);
    return {4{lane}};
  endfunction

  // Reference model: a plain queue of rows plus a read-count modulo TILE.
  logic [35:0] mq[$];
  int          tile_m = 0;
  bit          ovf_m = 0, udf_m = 0, vld_m = 0, last_m = 0;
  logic [35:0] data_m = '0;
  bit          full_m, empty_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      tile_m = 0; ovf_m = 0; udf_m = 0; vld_m = 0; last_m = 0; data_m = '0;
    end else if (flush) begin
      mq.delete();
      tile_m = 0; ovf_m = 0; udf_m = 0; vld_m = 0; last_m = 0;
    end else begin
      full_m  = (mq.size() == DEPTH);
      empty_m = (mq.size() == 0);
      if (wv && full_m)  ovf_m = 1;
      if (re && empty_m) udf_m = 1;
      vld_m  = re && !empty_m;
      last_m = 0;
      if (vld_m) begin
        data_m = mq.pop_front();
        last_m = (tile_m == TILE - 1);
        tile_m = (tile_m + 1) % TILE;
      end
      if (wv && !full_m) mq.push_back(wd);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("level",     level_o,        mq.size());
      chk("empty",     empty_o,        mq.size() == 0);
      chk("full",      full_o,         mq.size() == DEPTH);
      chk("afull",     afull_o,        mq.size() >= AFULL);
      chk("wr_ready",  wr_ready_o,     mq.size() != DEPTH);
      chk("ovf",       ovf_o,          ovf_m);
      chk("udf",       udf_o,          udf_m);
      chk("rd_valid",  rd_valid_o,     vld_m);
      chk("tile_last", rd_tile_last_o, last_m);
      chk("rd_data",   rd_data_o,      data_m);
    end
  end

  // Drive one cycle of inputs, return just after the following falling edge.
  task automatic cyc(input bit w, input logic [35:0] d, input bit r, input bit f);
    wv = w; wd = d; re = r; flush = f;
    @(negedge clk);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_valid"}, rd_valid_o,     0);
    chk({tag, "_last"},  rd_tile_last_o, 0);
    chk({tag, "_data"},  rd_data_o,      0);
    chk({tag, "_level"}, level_o,        0);
    chk({tag, "_empty"}, empty_o,        1);
    chk({tag, "_full"},  full_o,         0);
    chk({tag, "_afull"}, afull_o,        0);
    chk({tag, "_ready"}, wr_ready_o,     1);
    chk({tag, "_ovf"},   ovf_o,          0);
    chk({tag, "_udf"},   udf_o,          0);
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 reset_chk("rst");
    #9 rst = 1'b0;
    @(negedge clk);

    // Fill then drain
    for (int i = 0; i < 8; i++) begin
      cyc(1, row(i), 0, 0);
      if (i == 4) chk("afull_below", afull_o, 0);
      if (i == 5) chk("afull_at",    afull_o, 1);
    end
    chk("fill_full",  full_o,     1);
    chk("fill_ready", wr_ready_o, 0);
    chk("fill_level", level_o,    8);
    for (int i = 0; i < 8; i++) begin
      cyc(0, '0, 1, 0);
      chk("drain_valid", rd_valid_o,     1);
      chk("drain_data",  rd_data_o,      row(i));
      chk("drain_last",  rd_tile_last_o, (i % 4) == 3);
    end
    cyc(0, '0, 0, 0);
    chk("drain_empty", empty_o,    1);
    chk("valid_pulse", rd_valid_o, 0);
    chk("data_hold",   rd_data_o,  row(7));

    // Wrap-around
    for (int i = 0; i < 6; i++) cyc(1, row(i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0);
    for (int i = 6; i < 12; i++) cyc(1, row(i), 0, 0);
    chk("wrap_level", level_o, 7);
    for (int i = 0; i < 7; i++) begin
      cyc(0, '0, 1, 0);
      chk("wrap_data", rd_data_o, row(5 + i));
    end

    // Simultaneous write+read
    for (int i = 20; i < 24; i++) cyc(1, row(i), 0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1, row(24 + k), 1, 0);
      chk("sim_level", level_o,   4);
      chk("sim_data",  rd_data_o, row(20 + k));
    end
    for (int i = 34; i < 38; i++) cyc(1, row(i), 0, 0);
    chk("sim_full", full_o, 1);
    cyc(1, row(99), 1, 0);
    chk("full_rw_level", level_o,   7);
    chk("full_rw_ovf",   ovf_o,     1);
    chk("full_rw_data",  rd_data_o, row(30));
    for (int i = 0; i < 7; i++) cyc(0, '0, 1, 0);
    chk("full_rw_tail", rd_data_o, row(37));

    // Underflow and minimum latency
    cyc(0, '0, 1, 0);
    chk("udf_valid", rd_valid_o, 0);
    chk("udf_flag",  udf_o,      1);
    chk("udf_level", level_o,    0);
    cyc(1, row(50), 0, 0);
    cyc(0, '0, 1, 0);
    chk("lat_valid", rd_valid_o, 1);
    chk("lat_data",  rd_data_o,  row(50));
    cyc(1, row(51), 1, 0);
    chk("nobypass_valid", rd_valid_o, 0);
    chk("nobypass_level", level_o,    1);
    cyc(0, '0, 1, 0);
    chk("nobypass_data", rd_data_o, row(51));

    // Flush with concurrent write
    cyc(0, '0, 0, 1);
    for (int i = 60; i < 67; i++) cyc(1, row(i), 0, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 1, 0);
    chk("pre_flush_level", level_o, 5);
    cyc(1, row(77), 0, 1);
    chk("flush_level", level_o,    0);
    chk("flush_ovf",   ovf_o,      0);
    chk("flush_udf",   udf_o,      0);
    chk("flush_valid", rd_valid_o, 0);
    chk("flush_hold",  rd_data_o,  row(61));
    for (int i = 70; i < 74; i++) cyc(1, row(i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 1, 0);
      chk("flush_tile", rd_tile_last_o, i == 3);
      chk("flush_data", rd_data_o,      row(70 + i));
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit w, r, f;
      if (((n / 40) % 2) == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      f = ($urandom_range(0, 63) == 0);
      cyc(w, 36'($urandom()) ^ {4'h0, 32'($urandom())}, r, f);
    end

    // Asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) cyc(1, row(80 + i), 0, 0);
    cyc(1, row(83), 1, 0);
    wv = 1'b1; re = 1'b1; wd = row(84);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_chk("arst");
    @(negedge clk);
    #2 rst = 1'b0;
    wv = 1'b0; re = 1'b0;
    @(negedge clk);
    for (int i = 90; i < 94; i++) cyc(1, row(i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 1, 0);
      chk("arst_tile", rd_tile_last_o, i == 3);
      chk("arst_data", rd_data_o,      row(90 + i));
    end
    cyc(0, '0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
